// File: rtl/mem_stage_load.sv
//==============================================================================
// Module  : mem_stage_load
// Brief   : Pipeline MEM stage that captures and extends load data from the
//           data SRAM and feeds WB and the ID forwarding path.
//           Optional misaligned-load flag when ALIGN_CHECK_EN is defined.
// Revision: 1.0
//==============================================================================
`default_nettype none

module mem_stage_load #(
    parameter int ES_BUS_W = 76,
    parameter int WS_BUS_W = 70
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                ws_allowin,
    output logic                ms_allowin,
    input  logic                es_to_ms_valid,
    input  logic [ES_BUS_W-1:0] es_to_ms_bus,
    input  logic [31:0]         data_sram_rdata,
    output logic                ms_to_ws_valid,
    output logic [WS_BUS_W-1:0] ms_to_ws_bus,
    output logic [4:0]          ms_to_ds_dest,
    output logic [31:0]         ms_to_ds_value
`ifdef ALIGN_CHECK_EN
    ,
    output logic                ms_ale
`endif
);

    // Pipeline state
    logic                ms_valid_q, ms_valid_d;
    logic [ES_BUS_W-1:0] es_bus_q,   es_bus_d;
    logic [31:0]         rdata_q,    rdata_d;
    logic                hold_q,     hold_d;

    // Decoded fields of the latched EXE->MEM bus
    logic [4:0]  w_ld_op;
    logic        w_res_from_mem;
    logic        w_gr_we;
    logic [4:0]  w_dest;
    logic [31:0] w_alu_result;
    logic [31:0] w_pc;

    assign w_ld_op        = es_bus_q[75:71];
    assign w_res_from_mem = es_bus_q[70];
    assign w_gr_we        = es_bus_q[69];
    assign w_dest         = es_bus_q[68:64];
    assign w_alu_result   = es_bus_q[63:32];
    assign w_pc           = es_bus_q[31:0];

    assign ms_allowin     = !ms_valid_q || ws_allowin;
    assign ms_to_ws_valid = ms_valid_q;

    always_comb begin
        ms_valid_d = ms_valid_q;
        es_bus_d   = es_bus_q;
        rdata_d    = rdata_q;
        hold_d     = hold_q;
        if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
        end
        // SRAM data is only on the bus in the first MEM cycle; freeze it there.
        if (!hold_q) begin
            rdata_d = data_sram_rdata;
        end
        if (ms_valid_q && !hold_q) begin
            hold_d = 1'b1;
        end
        // A newly accepted instruction always starts on live SRAM data.
        if (es_to_ms_valid && ms_allowin) begin
            es_bus_d = es_to_ms_bus;
            hold_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ms_valid_q <= 1'b0;
            es_bus_q   <= '0;
            rdata_q    <= 32'h0;
            hold_q     <= 1'b0;
        end else begin
            ms_valid_q <= ms_valid_d;
            es_bus_q   <= es_bus_d;
            rdata_q    <= rdata_d;
            hold_q     <= hold_d;
        end
    end

    // Load lane extraction
    logic [1:0]  w_addr;
    logic [31:0] w_rdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_is_w, w_is_b, w_is_h, w_is_bu, w_is_hu;
    logic [31:0] w_load_data;
    logic [31:0] w_final_result;

    assign w_addr  = w_alu_result[1:0];
    assign w_rdata = hold_q ? rdata_q : data_sram_rdata;
    assign w_half  = w_addr[1] ? w_rdata[31:16] : w_rdata[15:0];

    always_comb begin
        w_byte = w_rdata[7:0];
        case (w_addr)
            2'd0:    w_byte = w_rdata[7:0];
            2'd1:    w_byte = w_rdata[15:8];
            2'd2:    w_byte = w_rdata[23:16];
            default: w_byte = w_rdata[31:24];
        endcase
    end

    // Multi-hot ld_op resolves by priority; an empty ld_op on a load acts as ld.w.
    assign w_is_w  = w_ld_op[0] || (w_ld_op == 5'b0);
    assign w_is_b  = !w_ld_op[0] && w_ld_op[1];
    assign w_is_h  = !w_ld_op[0] && !w_ld_op[1] && w_ld_op[2];
    assign w_is_bu = !w_ld_op[0] && !w_ld_op[1] && !w_ld_op[2] && w_ld_op[3];
    assign w_is_hu = !w_ld_op[0] && !w_ld_op[1] && !w_ld_op[2] && !w_ld_op[3] && w_ld_op[4];

    always_comb begin
        w_load_data = w_rdata;
        if (w_is_b) begin
            w_load_data = {{24{w_byte[7]}}, w_byte};
        end else if (w_is_h) begin
            w_load_data = {{16{w_half[15]}}, w_half};
        end else if (w_is_bu) begin
            w_load_data = {24'h0, w_byte};
        end else if (w_is_hu) begin
            w_load_data = {16'h0, w_half};
        end
    end

    assign w_final_result = w_res_from_mem ? w_load_data : w_alu_result;

    logic w_gr_we_eff;

`ifdef ALIGN_CHECK_EN
    logic w_ale;
    assign w_ale = ms_valid_q && w_res_from_mem &&
                   (((w_is_h || w_is_hu) && w_addr[0]) || (w_is_w && (w_addr != 2'd0)));
    assign ms_ale      = w_ale;
    assign w_gr_we_eff = w_gr_we && !w_ale;
`else
    assign w_gr_we_eff = w_gr_we;
`endif

    assign ms_to_ws_bus   = {w_gr_we_eff, w_dest, w_final_result, w_pc};
    assign ms_to_ds_dest  = (ms_valid_q && w_gr_we_eff) ? w_dest : 5'd0;
    assign ms_to_ds_value = (ms_valid_q && w_gr_we_eff) ? w_final_result : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_load.sv
//==============================================================================
// Module  : tb_mem_stage_load
// Brief   : Self-checking bench for mem_stage_load (table, random, corner seqs).
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_mem_stage_load;

    logic        clk;
    logic        resetn;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [75:0] es_to_ms_bus;
    logic [31:0] data_sram_rdata;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [4:0]  ms_to_ds_dest;
    logic [31:0] ms_to_ds_value;
`ifdef ALIGN_CHECK_EN
    logic        ms_ale;
`endif

    int errors = 0;
    int checks = 0;

    mem_stage_load #(.ES_BUS_W(76), .WS_BUS_W(70)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .ws_allowin      (ws_allowin),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .data_sram_rdata (data_sram_rdata),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_to_ws_bus    (ms_to_ws_bus),
        .ms_to_ds_dest   (ms_to_ds_dest),
        .ms_to_ds_value  (ms_to_ds_value)
`ifdef ALIGN_CHECK_EN
        ,
        .ms_ale          (ms_ale)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [4:0] OP_W  = 5'b00001;
    localparam logic [4:0] OP_B  = 5'b00010;
    localparam logic [4:0] OP_H  = 5'b00100;
    localparam logic [4:0] OP_BU = 5'b01000;
    localparam logic [4:0] OP_HU = 5'b10000;

    typedef struct {
        logic [4:0]  op;
        logic        rfm;
        logic        we;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Reference: which load kind wins for a given ld_op (0=w 1=b 2=h 3=bu 4=hu)
    function automatic int load_kind(input logic [4:0] op);
        if (op[0] || op == 5'b0) return 0;
        if (op[1]) return 1;
        if (op[2]) return 2;
        if (op[3]) return 3;
        return 4;
    endfunction

    function automatic logic [31:0] model_result(input logic [4:0] op, input logic rfm,
                                                 input logic [31:0] alu, input logic [31:0] rd);
        int unsigned a;
        int unsigned b;
        int unsigned h;
        if (!rfm) return alu;
        a = alu % 4;
        b = (rd >> (8 * a)) & 32'hFF;
        h = (rd >> ((a >= 2) ? 16 : 0)) & 32'hFFFF;
        case (load_kind(op))
            0:       return rd;
            1:       return (b >= 128) ? (b + 32'hFFFF_FF00) : b;
            2:       return (h >= 32768) ? (h + 32'hFFFF_0000) : h;
            3:       return b;
            default: return h;
        endcase
    endfunction

    function automatic logic model_ale(input logic [4:0] op, input logic rfm, input logic [31:0] alu);
`ifdef ALIGN_CHECK_EN
        int k;
        int unsigned a;
        k = load_kind(op);
        a = alu % 4;
        if (!rfm) return 1'b0;
        if ((k == 2 || k == 4) && (a % 2 == 1)) return 1'b1;
        if (k == 0 && a != 0) return 1'b1;
        return 1'b0;
`else
        return (op == 5'h1F) && rfm && (alu == 32'h0) && 1'b0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic mem_checks(input string tag, input logic [31:0] exp, input logic [31:0] pc,
                              input logic we, input logic [4:0] dest, input logic ale);
        logic we_eff;
        we_eff = we && !ale;
        chk({tag, " valid"},    {31'h0, ms_to_ws_valid},   32'h1);
        chk({tag, " allowin"},  {31'h0, ms_allowin},       {31'h0, ws_allowin});
        chk({tag, " result"},   ms_to_ws_bus[63:32],        exp);
        chk({tag, " pc"},       ms_to_ws_bus[31:0],         pc);
        chk({tag, " ws_we"},    {31'h0, ms_to_ws_bus[69]}, {31'h0, we_eff});
        chk({tag, " ws_dest"},  {27'h0, ms_to_ws_bus[68:64]}, {27'h0, dest});
        chk({tag, " fwd_dest"}, {27'h0, ms_to_ds_dest},    we_eff ? {27'h0, dest} : 32'h0);
        chk({tag, " fwd_val"},  ms_to_ds_value,             we_eff ? exp : 32'h0);
`ifdef ALIGN_CHECK_EN
        chk({tag, " ale"},      {31'h0, ms_ale},            {31'h0, ale});
`endif
    endtask

    // One instruction through MEM with an optional WB stall; SRAM data is scrambled while stalled.
    task automatic run_instr(input string tag, input logic [4:0] op, input logic rfm, input logic we,
                             input logic [4:0] dest, input logic [31:0] alu, input logic [31:0] pc,
                             input logic [31:0] rd, input int stall, input logic [31:0] exp);
        logic ale;
        ale = model_ale(op, rfm, alu);
        step();
        es_to_ms_valid  = 1'b1;
        es_to_ms_bus    = {op, rfm, we, dest, alu, pc};
        ws_allowin      = 1'b1;
        data_sram_rdata = $urandom();
        step();
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = rd;
        ws_allowin      = (stall == 0);
        #3;
        mem_checks(tag, exp, pc, we, dest, ale);
        for (int s = 1; s <= stall; s++) begin
            step();
            data_sram_rdata = $urandom();
            ws_allowin      = (s == stall);
            es_to_ms_valid  = (s < stall);
            es_to_ms_bus    = {OP_B, 1'b1, 1'b1, 5'd31, ~alu, ~pc};
            #3;
            mem_checks({tag, " stall"}, exp, pc, we, dest, ale);
        end
    endtask

    initial begin
        resetn          = 1'b0;
        ws_allowin      = 1'b1;
        es_to_ms_valid  = 1'b0;
        es_to_ms_bus    = '0;
        data_sram_rdata = 32'h0;

        vecs.push_back('{OP_B,  1'b1, 1'b1, 5'd3,  32'h1000_0001, 32'h1234_80FF, 32'hFFFF_FF80});
        vecs.push_back('{OP_BU, 1'b1, 1'b1, 5'd4,  32'h1000_0001, 32'h1234_80FF, 32'h0000_0080});
        vecs.push_back('{OP_H,  1'b1, 1'b1, 5'd6,  32'h2000_0002, 32'h8001_0000, 32'hFFFF_8001});
        vecs.push_back('{OP_HU, 1'b1, 1'b1, 5'd7,  32'h2000_0002, 32'h8001_0000, 32'h0000_8001});
        vecs.push_back('{OP_W,  1'b1, 1'b1, 5'd8,  32'h2000_0002, 32'h8001_0000, 32'h8001_0000});
        vecs.push_back('{OP_W,  1'b0, 1'b1, 5'd5,  32'h0000_0042, 32'hFFFF_FFFF, 32'h0000_0042});
        vecs.push_back('{OP_B,  1'b1, 1'b1, 5'd9,  32'h0000_0003, 32'h7F00_0000, 32'h0000_007F});
        vecs.push_back('{OP_H,  1'b1, 1'b1, 5'd10, 32'h0000_0000, 32'h0000_FFFE, 32'hFFFF_FFFE});
        vecs.push_back('{5'b0,  1'b1, 1'b1, 5'd11, 32'h0000_0000, 32'hCAFE_BABE, 32'hCAFE_BABE});
        vecs.push_back('{5'b00110, 1'b1, 1'b1, 5'd12, 32'h0000_0000, 32'h0000_80F0, 32'hFFFF_FFF0});
        vecs.push_back('{OP_BU, 1'b1, 1'b0, 5'd13, 32'h0000_0002, 32'h00AB_0000, 32'h0000_00AB});
        vecs.push_back('{OP_H,  1'b1, 1'b1, 5'd14, 32'h0000_0003, 32'h8001_0000, 32'hFFFF_8001});
        vecs.push_back('{OP_HU, 1'b1, 1'b1, 5'd15, 32'h0000_0001, 32'h1234_F00D, 32'h0000_F00D});

        // Reset state
        step();
        step();
        #3;
        chk("rst valid",   {31'h0, ms_to_ws_valid}, 32'h0);
        chk("rst allowin", {31'h0, ms_allowin},     32'h1);
        chk("rst bus_res", ms_to_ws_bus[63:32],      32'h0);
        chk("rst bus_pc",  ms_to_ws_bus[31:0],       32'h0);
        chk("rst fwd_dst", {27'h0, ms_to_ds_dest},  32'h0);
        chk("rst fwd_val", ms_to_ds_value,           32'h0);
        step();
        resetn = 1'b1;

        foreach (vecs[i]) begin
            run_instr($sformatf("vec%0d", i), vecs[i].op, vecs[i].rfm, vecs[i].we, vecs[i].dest,
                      vecs[i].alu, 32'h1C00_0000 + 32'(i * 4), vecs[i].rdata, 0, vecs[i].exp);
        end

        // ld.w held across a 3-cycle WB stall while the SRAM bus changes
        step();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = {OP_W, 1'b1, 1'b1, 5'd20, 32'h0000_1000, 32'h1C00_1000};
        ws_allowin     = 1'b0;
        step();
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = 32'h1111_2222;
        #3;
        chk("stall c0 res", ms_to_ws_bus[63:32], 32'h1111_2222);
        for (int c = 1; c <= 3; c++) begin
            step();
            data_sram_rdata = 32'hDEAD_BEEF;
            es_to_ms_valid  = 1'b1;
            es_to_ms_bus    = {OP_B, 1'b1, 1'b1, 5'd21, 32'h0, 32'h1C00_2000};
            #3;
            chk($sformatf("stall c%0d res", c), ms_to_ws_bus[63:32], 32'h1111_2222);
            chk($sformatf("stall c%0d fwd", c), ms_to_ds_value,      32'h1111_2222);
            chk($sformatf("stall c%0d pc", c),  ms_to_ws_bus[31:0],  32'h1C00_1000);
            chk($sformatf("stall c%0d allowin", c), {31'h0, ms_allowin}, 32'h0);
        end
        es_to_ms_valid = 1'b0;
        ws_allowin     = 1'b1;

        // Back-to-back loads with no stall: the second must use its own live data
        step();
        es_to_ms_valid  = 1'b1;
        es_to_ms_bus    = {OP_W, 1'b1, 1'b1, 5'd1, 32'h0000_0100, 32'h1C00_3000};
        step();
        es_to_ms_bus    = {OP_B, 1'b1, 1'b1, 5'd2, 32'h0000_0101, 32'h1C00_3004};
        data_sram_rdata = 32'hAAAA_5555;
        #3;
        chk("b2b A res", ms_to_ws_bus[63:32], 32'hAAAA_5555);
        step();
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = 32'h0000_9100;
        #3;
        chk("b2b B res", ms_to_ws_bus[63:32], 32'hFFFF_FF91);
        chk("b2b B pc",  ms_to_ws_bus[31:0],  32'h1C00_3004);

        // Reset while stalled drops the instruction
        step();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = {OP_W, 1'b0, 1'b1, 5'd9, 32'h0000_0042, 32'h1C00_4000};
        ws_allowin     = 1'b0;
        step();
        es_to_ms_valid = 1'b0;
        #3;
        chk("rstmid pre valid", {31'h0, ms_to_ws_valid}, 32'h1);
        step();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        #3;
        chk("rstmid valid",   {31'h0, ms_to_ws_valid}, 32'h0);
        chk("rstmid fwd_dst", {27'h0, ms_to_ds_dest},  32'h0);
        chk("rstmid fwd_val", ms_to_ds_value,           32'h0);
        chk("rstmid allowin", {31'h0, ms_allowin},     32'h1);
        ws_allowin = 1'b1;

        // Randomised instructions and stalls against the reference model
        for (int n = 0; n < 40; n++) begin
            logic [4:0]  op;
            logic        rfm;
            logic [31:0] alu;
            logic [31:0] rd;
            if ($urandom_range(0, 3) != 0) op = 5'(1 << $urandom_range(0, 4));
            else                          op = 5'($urandom_range(0, 31));
            rfm = ($urandom_range(0, 4) != 0);
            alu = $urandom();
            rd  = $urandom();
            run_instr($sformatf("rnd%0d", n), op, rfm, 1'($urandom_range(0, 1)),
                      5'($urandom_range(0, 31)), alu, $urandom(), rd,
                      int'($urandom_range(0, 2)), model_result(op, rfm, alu, rd));
        end

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
